// File: rtl/vga_multiball.sv
// ============================================================================
// Module   : vga_multiball
// Purpose  : Multi-ball sprite engine for the 640x480 VGA pipeline. Draws
//            NBALL square balls, latches edge collisions while the visible
//            area is scanned and moves one ball per cycle offscreen.
//            Optional macro VGA_MULTIBALL_COLLIDE_EN adds ball-to-ball bounce.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_multiball #(
  parameter int NBALL    = 4,
  parameter int SIZE     = 6,
  parameter int STEP     = 1,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XSPACE   = 97,
  parameter int YSPACE   = 61
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       videoactive,
  input  logic       offscreen,
  input  logic       coll_top,
  input  logic       coll_right,
  input  logic       coll_bottom,
  input  logic       coll_left,
  output logic       pixel_ball,
  output logic [2:0] pixel_id,
  output logic       frame_tick
);

  localparam logic [9:0]  c_SIZE_M1 = 10'(SIZE - 1);
  localparam logic [10:0] c_STEP11  = 11'(STEP);
  localparam logic [10:0] c_H11     = 11'(H_ACTIVE);
  localparam logic [10:0] c_V11     = 11'(V_ACTIVE);
  localparam logic [2:0]  c_K_LAST  = 3'(NBALL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_k;
  logic [2:0]       w_k_next;
  logic [NBALL-1:0] w_hit;

  // One-axis move with wrap; sums are 11 bits so x+STEP never overflows.
  function automatic logic [9:0] f_move(input logic [9:0]  pos,
                                        input logic        neg,
                                        input logic [10:0] lim);
    logic [10:0] s;
    if (!neg) begin
      s = {1'b0, pos} + c_STEP11;
      if (s > lim - 11'd1) s = s - lim;
    end else if ({1'b0, pos} < c_STEP11) begin
      s = {1'b0, pos} + lim - c_STEP11;
    end else begin
      s = {1'b0, pos} - c_STEP11;
    end
    return 10'(s);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    frame_tick   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!offscreen) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        if (offscreen) begin
          w_state_next = S_UPDATE;
          w_k_next     = '0;
        end
      end
      S_UPDATE: begin
        if (r_k == c_K_LAST) w_state_next = S_DONE;
        else                 w_k_next     = r_k + 3'd1;
      end
      S_DONE: begin
        frame_tick   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef VGA_MULTIBALL_COLLIDE_EN
  localparam logic [NBALL-1:0] c_ONE = NBALL'(1);
  logic w_multi;
  // Clearing the lowest set bit leaves something only if two balls overlap.
  assign w_multi = |(w_hit & (w_hit - c_ONE));
`endif

  // ---------------------------------------------------------------- balls
  for (genvar i = 0; i < NBALL; i++) begin : g_ball
    localparam logic [9:0] c_X0  = 10'((i * XSPACE) % H_ACTIVE);
    localparam logic [9:0] c_Y0  = 10'((i * YSPACE) % V_ACTIVE);
    localparam logic       c_DH0 = 1'(i % 2);
    localparam logic       c_DV0 = 1'((i / 2) % 2);

    logic [9:0] r_x, r_y;
    logic       r_dir_h, r_dir_v;
    logic       r_cm_top, r_cm_right, r_cm_bottom, r_cm_left;
    logic [9:0] w_dx, w_dy;
    logic       w_dh, w_dv;
    logic       w_sel, w_mark;
`ifdef VGA_MULTIBALL_COLLIDE_EN
    logic       r_cm_ball;
`endif

    // Unsigned modulo-1024 differences make one compare per axis suffice.
    assign w_dx     = hc - r_x;
    assign w_dy     = vc - r_y;
    assign w_hit[i] = (w_dx <= c_SIZE_M1) && (w_dy <= c_SIZE_M1);
    assign w_sel    = (r_state == S_UPDATE) && (r_k == 3'(i));
    assign w_mark   = (r_state == S_SCAN) && videoactive && w_hit[i];

    always_comb begin
      w_dh = r_dir_h;
      w_dv = r_dir_v;
`ifdef VGA_MULTIBALL_COLLIDE_EN
      if (r_cm_ball) begin
        w_dh = ~r_dir_h;
        w_dv = ~r_dir_v;
      end
`endif
      if (r_cm_top && !r_cm_bottom)      w_dv = 1'b1;
      else if (r_cm_bottom && !r_cm_top) w_dv = 1'b0;
      if (r_cm_left && !r_cm_right)      w_dh = 1'b1;
      else if (r_cm_right && !r_cm_left) w_dh = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_x         <= c_X0;
        r_y         <= c_Y0;
        r_dir_h     <= c_DH0;
        r_dir_v     <= c_DV0;
        r_cm_top    <= 1'b0;
        r_cm_right  <= 1'b0;
        r_cm_bottom <= 1'b0;
        r_cm_left   <= 1'b0;
`ifdef VGA_MULTIBALL_COLLIDE_EN
        r_cm_ball   <= 1'b0;
`endif
      end else begin
        if (r_state == S_IDLE) begin
          r_cm_top    <= 1'b0;
          r_cm_right  <= 1'b0;
          r_cm_bottom <= 1'b0;
          r_cm_left   <= 1'b0;
`ifdef VGA_MULTIBALL_COLLIDE_EN
          r_cm_ball   <= 1'b0;
`endif
        end else if (w_mark) begin
          r_cm_top    <= r_cm_top    | coll_top;
          r_cm_right  <= r_cm_right  | coll_right;
          r_cm_bottom <= r_cm_bottom | coll_bottom;
          r_cm_left   <= r_cm_left   | coll_left;
`ifdef VGA_MULTIBALL_COLLIDE_EN
          r_cm_ball   <= r_cm_ball   | w_multi;
`endif
        end
        if (w_sel) begin
          r_dir_h <= w_dh;
          r_dir_v <= w_dv;
          r_x     <= f_move(r_x, w_dh, c_H11);
          r_y     <= f_move(r_y, w_dv, c_V11);
        end
      end
    end
  end

  // ---------------------------------------------------------------- pixel out
  always_comb begin
    pixel_id = '0;
    for (int i = NBALL - 1; i >= 0; i--) begin
      if (w_hit[i]) pixel_id = 3'(i);
    end
  end

  assign pixel_ball = (|w_hit) && videoactive;

endmodule

`default_nettype wire

// File: doc/vga_multiball.md
# vga_multiball

Parametrised multi-ball sprite engine for the 640x480 VGA pipeline. It tracks `NBALL` square balls, each with its own position and direction. During the visible area it detects collisions against the screen-edge collision zones. During the offscreen lines it updates every ball's direction and position, one ball per cycle. It sits between the VGA timing generator and the RGB mixer, replacing the single hard-coded ball of the previous top level.

## Interface
- `NBALL`, 4: number of balls, 1..8.
- `SIZE`, 6: ball edge length in pixels; ball covers `x..x+SIZE-1`, `y..y+SIZE-1`.
- `STEP`, 1: pixels moved per axis per frame, 1..15.
- `H_ACTIVE`, 640: visible width; x range `0..H_ACTIVE-1`.
- `V_ACTIVE`, 480: visible height; y range `0..V_ACTIVE-1`.
- `XSPACE`, 97: initial x spacing between balls.
- `YSPACE`, 61: initial y spacing between balls.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high. Clock is `clk`.
- `hc` in 10: current horizontal pixel counter.
- `vc` in 10: current vertical pixel counter.
- `videoactive` in 1: pixel is inside the visible area.
- `offscreen` in 1: high on lines outside the visible area.
- `coll_top`, `coll_right`, `coll_bottom`, `coll_left` in 1 each: current pixel lies in that edge's collision zone.
- `pixel_ball` out 1: current pixel belongs to any ball, gated by `videoactive`.
- `pixel_id` out 3: index of the lowest-numbered ball covering the current pixel; 0 when none.
- `frame_tick` out 1: one-cycle pulse when all balls have been updated.

## Operation
- Ball hit, per ball i: `(hc - x[i]) <= SIZE-1` and `(vc - y[i]) <= SIZE-1`. Both subtractions are 10-bit unsigned (modulo 1024).
- `pixel_ball` is the OR of all ball hits, AND `videoactive`.
- Per-ball state:
  - `x`, `y`: 10 bits each.
  - `dir_h`: 0 = right (+), 1 = left (-).
  - `dir_v`: 0 = down (+), 1 = up (-).
  - Collision memory: `cm_top`, `cm_right`, `cm_bottom`, `cm_left`.
- Reset values:
  - `x[i] = (i*XSPACE) mod H_ACTIVE`, `y[i] = (i*YSPACE) mod V_ACTIVE`.
  - `dir_h[i] = i[0]`, `dir_v[i] = i[1]`.
  - All collision memories 0, state IDLE, `frame_tick` 0.
- FSM:
  - **IDLE**: clear all collision memories. Go to SCAN when `offscreen == 0`.
  - **SCAN**: each cycle, for each ball i whose hit AND `videoactive` is true, set `cm_*[i]` for every asserted `coll_*`. Go to UPDATE with index `k = 0` when `offscreen == 1`.
  - **UPDATE**: process ball k in one cycle. Increment k. After k = NBALL-1, go to DONE.
  - **DONE**: pulse `frame_tick` for 1 cycle, then go to IDLE.
- Direction rules, applied to ball k in UPDATE:
  - `top & !bottom` sets `dir_v = 1`.
  - `bottom & !top` sets `dir_v = 0`.
  - `left & !right` sets `dir_h = 1`.
  - `right & !left` sets `dir_h = 0`.
  - Both of a pair set: that axis is unchanged.
- Move: ball k moves in the same UPDATE cycle, using the newly computed direction.
  - Right: `x + STEP`. If the result is greater than `H_ACTIVE-1`, use `x + STEP - H_ACTIVE` (wrap).
  - Left: if `x < STEP`, use `x + H_ACTIVE - STEP`; otherwise `x - STEP`.
  - The y axis follows the same rules with `V_ACTIVE`.
  - Internal sums are 11 bits wide, so there is no overflow.

## Timing
- `pixel_ball` and `pixel_id` are combinational from `hc`, `vc` and the registered positions. Latency is 0 cycles.
- Collision memories register 1 cycle after the qualifying pixel.
- UPDATE takes exactly `NBALL` cycles. `frame_tick` follows 1 cycle later. Everything completes well inside the first offscreen line.
- Ball state changes only in UPDATE. Positions are therefore stable throughout the visible area.
- Reset asserted in any state restores all reset values on the next edge. This includes partially updated ball sets.
- `offscreen` returning to 0 during UPDATE does not abort the update. IDLE then waits for the next visible region.

## Configuration
- `VGA_MULTIBALL_COLLIDE_EN` defined: ball-to-ball collisions are enabled.
  - In SCAN, any visible pixel covered by two or more balls sets `cm_ball[i]` for every ball covering it.
  - In UPDATE, a ball with `cm_ball` set inverts both `dir_h` and `dir_v` before the edge rules are applied. Edge rules then override the affected axis.
  - `cm_ball` clears in IDLE.
- Macro undefined: balls pass through each other. No `cm_ball` logic is present.

## Test plan
- **Reset**, NBALL=4: after reset, ball 1 is at (97,61) with `dir_h=1`, `dir_v=0`; ball 3 is at (291,183) moving left/up; `pixel_ball=0` with `videoactive=0`.
- **Free move**: one frame with no `coll_*` asserted. Ball 0 moves (0,0) to (1,1). `frame_tick` pulses exactly `NBALL+1` cycles after `offscreen` rises.
- **Right wrap**, STEP=3: ball at x=638 moving right ends the frame at x=1. A ball at x=2 moving left ends at x=639.
- **Edge bounce**: `coll_left` asserted while ball 0 is drawn. After UPDATE, `dir_h=1` and x drops by STEP. With `coll_left` and `coll_right` both hit, `dir_h` is unchanged.
- **Priority and reset**: balls 0 and 2 overlap at pixel (100,100); `pixel_id=0` there. Reset asserted in UPDATE cycle k=1 returns all balls to their reset positions.
- **Ball collision** (`VGA_MULTIBALL_COLLIDE_EN`): two balls overlapping for one visible pixel both invert `dir_h` and `dir_v` at the next UPDATE. Without the macro, directions are unchanged.
